digit_serializer: RTL and testbench
===================================

DIGIT_SERIALIZER -- requirements
Module: digit_serializer

Interface
REQ-001 SHALL have parameter W, default 3: digit width in bits.
REQ-002 SHALL have parameter N, default 2: digits per operand.
REQ-003 SHALL have parameter G, default 0: idle gap cycles inserted after each operand pair.
REQ-004 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: parallel operand pair offered.
REQ-007 SHALL have port in_ready, output, 1: block accepts the pair this cycle.
REQ-008 SHALL have port in_a, input, N*W: operand A, least-significant digit in bits [W-1:0].
REQ-009 SHALL have port in_b, input, N*W: operand B, same packing as in_a.
REQ-010 SHALL have port a, output, W: current digit of A, registered.
REQ-011 SHALL have port b, output, W: current digit of B, registered.
REQ-012 SHALL have port digit_valid, output, 1: a and b carry a live digit.
REQ-013 SHALL have port first_digit, output, 1: current digit is digit 0; drives the adder carry-clear.
REQ-014 SHALL have port last_digit, output, 1: current digit is digit N-1.

Function
REQ-015 SHALL transfer a pair when in_valid and in_ready are both high at a posedge; in_a and in_b are captured in full at that edge.
REQ-016 SHALL implement FSM states IDLE, SHIFT, GAP: IDLE -> SHIFT on transfer; SHIFT -> GAP after digit N-1 when G>0; GAP -> IDLE after G cycles; SHIFT -> IDLE after digit N-1 when G=0 and no new transfer.
REQ-017 SHALL drive digit i of the pair on a and b during cycle k+1+i, where k is the transfer edge and i = 0..N-1, with no bubbles between digits.
REQ-018 SHALL assert first_digit only with digit 0 and last_digit only with digit N-1; both SHALL be high together when N=1.
REQ-019 SHALL hold digit_valid high for exactly N consecutive cycles per pair.
REQ-020 SHALL drive in_ready high in IDLE, and in SHIFT during digit N-1 when G=0, so that back-to-back pairs stream with first_digit immediately following last_digit.
REQ-021 SHALL drive in_ready low in GAP and in all other SHIFT cycles.
REQ-022 SHALL drive a, b, first_digit and last_digit to 0 whenever digit_valid is low.
REQ-023 SHALL ignore operand changes after capture; a pair in flight SHALL be unaffected by in_a or in_b.
REQ-024 SHALL use a digit counter of width $clog2(N) (minimum 1) that wraps to 0 on each new transfer.
REQ-025 SHALL provide no back-pressure on the output side; the downstream adder consumes one digit per clock.

Reset
REQ-026 SHALL, while reset is high, force state IDLE, counter 0, and a, b, digit_valid, first_digit, last_digit, in_ready all 0.
REQ-027 SHALL abort any pair in flight when reset asserts mid-operation; no remaining digits are emitted after release.
REQ-028 SHALL raise in_ready on the first posedge after reset deasserts.

Structure
REQ-029 SHALL place the default W, N and G values and the state enum type in shared package digit_serial_pkg, also imported by the adder bench.
REQ-030 SHALL implement the operand holding registers as one sub-module, digit_shift_reg, instantiated twice (A and B), shifting right by W per digit.

Verification
REQ-031 SHALL verify, with W=3 and N=2: in_a=1, in_b=2 -> (a,b) = (1,2) with first_digit, then (0,0) with last_digit; digit_valid high for 2 cycles.
REQ-032 SHALL verify in_a=6'o35, in_b=6'o12 -> digits (5,2) then (3,1); fed through digit_serial_adder, the reassembled sum = 6'o47.
REQ-033 SHALL verify, with G=0, in_valid held high across 3 pairs -> 6 contiguous digit_valid cycles, with first_digit at cycles 1, 3, 5.
REQ-034 SHALL verify, with G=2: in_ready low for the 2 cycles after last_digit; a second pair offered during that window is accepted only on re-entry to IDLE.
REQ-035 SHALL verify reset asserted during digit 0 -> all outputs 0 immediately; no digit 1 emitted; in_ready high one cycle after release.
REQ-036 SHALL verify in_a and in_b changed every cycle after the transfer edge -> emitted digits match only the captured values.

Source files
------------

// File: rtl/digit_serial_pkg.sv
// Shared defaults and state type for the digit-serial datapath
// (also imported by the adder bench).
package digit_serial_pkg;

    localparam int unsigned DIGIT_W_DEF  = 3;
    localparam int unsigned N_DIGITS_DEF = 2;
    localparam int unsigned GAP_DEF      = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_t;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Operand holding register: captures an N-digit word, emits it one
// registered digit per shift, least-significant digit first.
module digit_shift_reg
    import digit_serial_pkg::*;
#(
    parameter int unsigned W = DIGIT_W_DEF,
    parameter int unsigned N = N_DIGITS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic [N*W-1:0] par_i,
    output logic [W-1:0]   digit_o
);

    logic [N*W-1:0] rest_q, rest_d;
    logic [W-1:0]   digit_q, digit_d;

    // The digit register is cleared on any cycle that neither loads nor
    // shifts, so the output is zero whenever no digit is live.
    always_comb begin
        rest_d  = rest_q;
        digit_d = '0;
        if (load_i) begin
            digit_d = par_i[W-1:0];
            rest_d  = par_i >> W;
        end else if (shift_i) begin
            digit_d = rest_q[W-1:0];
            rest_d  = rest_q >> W;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rest_q  <= '0;
            digit_q <= '0;
        end else begin
            rest_q  <= rest_d;
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/digit_serializer.sv
// Parallel-to-serial converter feeding a digit-serial adder: one operand
// pair in, N registered digit pairs out with first/last markers.
module digit_serializer
    import digit_serial_pkg::*;
#(
    parameter int unsigned W = DIGIT_W_DEF,
    parameter int unsigned N = N_DIGITS_DEF,
    parameter int unsigned G = GAP_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    output logic [W-1:0]   a,
    output logic [W-1:0]   b,
    output logic           digit_valid,
    output logic           first_digit,
    output logic           last_digit
);

    localparam int unsigned    CW       = cnt_width(N);
    localparam int unsigned    GW       = cnt_width(G);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((G > 0) ? (G - 1) : 0);

    ser_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rdy_q, rdy_d;
    logic          dv_q, dv_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          xfer, load, shift;

    assign xfer = in_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // A transfer here is only possible with G=0: rdy_q is low otherwise.
                    if (xfer) begin
                        cnt_d = '0;
                        load  = 1'b1;
                    end else if (G > 0) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state so they line up with the digits.
        dv_d    = (state_d == ST_SHIFT);
        first_d = dv_d && (cnt_d == '0);
        last_d  = dv_d && (cnt_d == CNT_LAST);
        rdy_d   = (state_d == ST_IDLE) || ((G == 0) && last_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            rdy_q   <= 1'b0;
            dv_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rdy_q   <= rdy_d;
            dv_q    <= dv_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    digit_shift_reg #(.W(W), .N(N)) u_sr_a (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .par_i   (in_a),
        .digit_o (a)
    );

    digit_shift_reg #(.W(W), .N(N)) u_sr_b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .par_i   (in_b),
        .digit_o (b)
    );

    assign in_ready    = rdy_q;
    assign digit_valid = dv_q;
    assign first_digit = first_q;
    assign last_digit  = last_q;

    p_quiet_when_idle: assert property (@(posedge clk) disable iff (reset)
        !digit_valid |-> (a == '0 && b == '0 && !first_digit && !last_digit));

    p_no_ready_in_gap: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_GAP) |-> !in_ready);

endmodule

// File: tb/tb_digit_serializer.sv
// Bench for digit_serializer: two instances (G=0 and G=2) share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_digit_serializer;

    localparam int unsigned W  = 3;
    localparam int unsigned N  = 2;
    localparam int unsigned NW = N * W;
    localparam int unsigned OW = 4 + 2 * W;

    typedef struct packed {
        logic         v;
        logic         f;
        logic         l;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [NW-1:0] in_a, in_b;
    logic          rdy [2];
    logic          dv  [2];
    logic          fd  [2];
    logic          ld  [2];
    logic [W-1:0]  da  [2];
    logic [W-1:0]  db  [2];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   ready_from [2];
    exp_t mq [2][$];

    logic [11:0]   dvm, fm, rm;
    logic [3:0]    s;
    logic          carry;
    logic [NW-1:0] sumv;
    int            acc;

    digit_serializer #(.W(W), .N(N), .G(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .a(da[0]), .b(db[0]),
        .digit_valid(dv[0]), .first_digit(fd[0]), .last_digit(ld[0])
    );

    digit_serializer #(.W(W), .N(N), .G(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .a(da[1]), .b(db[1]),
        .digit_valid(dv[1]), .first_digit(fd[1]), .last_digit(ld[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    function automatic int unsigned gval(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [OW-1:0] obs(input int k);
        return {rdy[k], dv[k], fd[k], ld[k], da[k], db[k]};
    endfunction

    // One clock: check both DUTs against the model at negedge, then let the
    // model take any transfer decided by the current inputs.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            logic er;
            e = '0;
            if (reset) mq[k].delete();
            else if (mq[k].size() > 0) e = mq[k].pop_front();
            er = !reset && (cyc >= ready_from[k]);
            chk((k == 0) ? "g0_cycle" : "g2_cycle", 32'(obs(k)),
                32'({er, e.v, e.f, e.l, e.a, e.b}));
            if (reset) begin
                ready_from[k] = cyc + 2;
            end else if (in_valid && er) begin
                for (int i = 0; i < int'(N); i++) begin
                    exp_t d;
                    d.v = 1'b1;
                    d.f = (i == 0);
                    d.l = (i == int'(N) - 1);
                    d.a = W'(in_a >> (W * i));
                    d.b = W'(in_b >> (W * i));
                    mq[k].push_back(d);
                end
                ready_from[k] = (gval(k) == 0) ? cyc + int'(N)
                                               : cyc + int'(N) + int'(gval(k)) + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        ready_from[0] = 0;
        ready_from[1] = 0;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("rst_outputs", 32'(obs(0)), 32'd0);
        reset = 1'b0;
        step();

        // Basic pair 1,2
        in_valid = 1'b1; in_a = NW'(1); in_b = NW'(2);
        step();
        in_valid = 1'b0;
        chk("r31_digit0", 32'({dv[0], fd[0], ld[0], da[0], db[0]}), 32'({1'b1, 1'b1, 1'b0, 3'd1, 3'd2}));
        step();
        chk("r31_digit1", 32'({dv[0], fd[0], ld[0], da[0], db[0]}), 32'({1'b1, 1'b0, 1'b1, 3'd0, 3'd0}));
        step();
        chk("r31_done", 32'({dv[0], fd[0], ld[0], da[0], db[0]}), 32'd0);

        // Octal 35 + 12 through a behavioural digit-serial adder
        idle(6);
        in_valid = 1'b1; in_a = 6'o35; in_b = 6'o12;
        step();
        in_valid = 1'b0;
        chk("r32_digit0", 32'({da[0], db[0]}), 32'({3'd5, 3'd2}));
        carry = 1'b0;
        sumv  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (fd[0]) carry = 1'b0;
            s = {1'b0, da[0]} + {1'b0, db[0]} + {3'b000, carry};
            sumv[W*i +: W] = s[W-1:0];
            carry = s[W];
            if (i == 1) chk("r32_digit1", 32'({da[0], db[0]}), 32'({3'd3, 3'd1}));
            step();
        end
        chk("r32_sum", 32'(sumv), 32'(6'o47));

        // Three back-to-back pairs with in_valid held high, operands churning
        idle(6);
        acc = 0; dvm = '0; fm = '0;
        for (int t = 0; t < 12; t++) begin
            in_valid = (acc < 3);
            in_a = NW'($urandom);
            in_b = NW'($urandom);
            if (in_valid && cyc >= ready_from[0]) acc++;
            step();
            dvm[t] = dv[0];
            fm[t]  = fd[0];
        end
        chk("r33_valid_run", 32'(dvm), 32'h03F);
        chk("r33_first_pos", 32'(fm), 32'h015);

        // Gap handling on the G=2 instance
        idle(6);
        in_valid = 1'b1; in_a = 6'o64; in_b = 6'o17;
        rm = '0; dvm = '0;
        for (int t = 0; t < 10; t++) begin
            step();
            rm[t]  = rdy[1];
            dvm[t] = dv[1];
        end
        chk("r34_ready", 32'(rm), 32'h210);
        chk("r34_valid", 32'(dvm), 32'h063);

        // Reset during digit 0
        idle(6);
        in_valid = 1'b1; in_a = 6'o71; in_b = 6'o26;
        step();
        in_valid = 1'b0;
        chk("r35_digit0", 32'({dv[0], da[0], db[0]}), 32'({1'b1, 3'd1, 3'd6}));
        reset = 1'b1;
        #1;
        chk("r35_async0", 32'(obs(0)), 32'd0);
        chk("r35_async2", 32'(obs(1)), 32'd0);
        step();
        reset = 1'b0;
        chk("r35_release", 32'(obs(0)), 32'd0);
        step();
        chk("r35_ready0", 32'(obs(0)), 32'({1'b1, {(OW-1){1'b0}}}));
        chk("r35_ready2", 32'(obs(1)), 32'({1'b1, {(OW-1){1'b0}}}));

        // Random traffic with operands changing every cycle and rare resets
        for (int t = 0; t < 400; t++) begin
            reset    = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = NW'($urandom);
            in_b     = NW'($urandom);
            step();
        end
        reset = 1'b0;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
